// File: rtl/psum_ofifo_pkg.sv
// psum_ofifo_pkg -- shared defaults for the psum realignment FIFO (rev 1.0)
`default_nettype none

package psum_ofifo_pkg;

  localparam int PSUM_BW     = 16;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 64;
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

  // Pointer width for a lane of the given depth: address bits plus one wrap bit.
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/psum_fifo_lane.sv
// psum_fifo_lane -- one register-based FIFO lane with combinational head read (rev 1.0)
`default_nettype none

module psum_fifo_lane
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               rd,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int PTR_W  = ptr_width(depth);
  localparam int ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [psum_bw-1:0] mem [depth];
  logic               push;

  // Same address with differing wrap bits means the writer has lapped the reader.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign push  = wr && !full;
  assign dout  = mem[rptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (rd)   rptr <= rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wptr[ADDR_W-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/psum_ofifo.sv
// psum_ofifo -- per-column FIFO lanes that release a full psum row once every lane has data (rev 1.0)
`default_nettype none

module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_overflow
);

  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [psum_bw*col-1:0] head;
  logic                   pop;

  assign o_ready = ~|lane_empty;
  assign o_full  = |lane_full;
  // Lanes trust this gating and never check for empty themselves.
  assign pop     = rd && o_ready;

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_fifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .din   (in[psum_bw*i +: psum_bw]),
      .rd    (pop),
      .dout  (head[psum_bw*i +: psum_bw]),
      .empty (lane_empty[i]),
      .full  (lane_full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out        <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= pop;
      if (pop) out <= head;
      // Full flags are pre-pop, so a write racing a pop on a full lane still counts as overflow.
      if (|(wr & lane_full)) o_overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire
